// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin load arbiter and its picker.
package arb_pkg;
  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping 7 -> 0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan from the farthest offset down so the nearest requester to ptr wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[ptr + IDX_W'(i)]) idx = ptr + IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_load_arbiter8.sv
// Round-robin owner of the shared 8-register load port, with bounded bursts and
// zero-bubble handover; drives the demux sel/load pair and the shared data bus.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; gnt = 0, busy = 0
//   ST_GRANT | sel owns the port; gnt = onehot(sel), busy = 1
module rr_load_arbiter8
  import arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  data_in,
  output logic [NREQ-1:0]        gnt,
  output logic [IDX_W-1:0]       sel,
  output logic                   load,
  output logic [WIDTH-1:0]       data_out,
  output logic                   busy
);

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_sel, w_sel_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;

  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_load;
  logic             w_release;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign busy     = (r_state == ST_GRANT);
  assign w_load   = busy & req[r_sel];
  assign load     = w_load;
  assign sel      = r_sel;
  assign gnt      = r_gnt;
  assign data_out = data_in[r_sel*WIDTH +: WIDTH];

  assign w_release = ~req[r_sel] | (w_load & (r_cnt == CNT_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick_idx;
          w_ptr_nxt   = w_pick_idx + IDX_W'(1);
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          // ptr already sits one past the owner, so the owner is scanned last.
          w_cnt_nxt = '0;
          if (w_pick_valid) begin
            w_sel_nxt = w_pick_idx;
            w_ptr_nxt = w_pick_idx + IDX_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_load) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_gnt_nxt = (w_state_nxt == ST_GRANT) ? (NREQ'(1) << w_sel_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_load_arbiter8.sv
// Directed scoreboard bench for rr_load_arbiter8: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_rr_load_arbiter8;
  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        req;
  logic [8*WIDTH-1:0] data_in;
  logic [7:0]        gnt;
  logic [2:0]        sel;
  logic              load;
  logic [WIDTH-1:0]  data_out;
  logic              busy;

  typedef struct {
    logic [7:0] gnt;
    int         sel;   // -1: sel/data_out not checked
    logic       busy;
    logic       load;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  rr_load_arbiter8 #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .sel      (sel),
    .load     (load),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] word(input int i);
    return 16'hA0A0 ^ (16'(i) * 16'h1111);
  endfunction

  task automatic v(input bit rst, input logic [7:0] r, input logic [7:0] g,
                   input int s, input bit b, input bit l);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    e.gnt = g; e.sel = s; e.busy = b; e.load = l;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (gnt !== e.gnt) begin
          n_miss++;
          $display("FAIL vec%0d gnt: got %h want %h", n_vec, gnt, e.gnt);
        end
        if (busy !== e.busy) begin
          n_miss++;
          $display("FAIL vec%0d busy: got %b want %b", n_vec, busy, e.busy);
        end
        if (load !== e.load) begin
          n_miss++;
          $display("FAIL vec%0d load: got %b want %b", n_vec, load, e.load);
        end
        if (e.sel >= 0) begin
          if (sel !== 3'(e.sel)) begin
            n_miss++;
            $display("FAIL vec%0d sel: got %0d want %0d", n_vec, sel, e.sel);
          end
          if (data_out !== word(e.sel)) begin
            n_miss++;
            $display("FAIL vec%0d data_out: got %h want %h", n_vec, data_out, word(e.sel));
          end
        end
        n_vec++;
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    req   = 8'hFF;
    for (int i = 0; i < 8; i++) data_in[i*WIDTH +: WIDTH] = word(i);

    // Reset held two cycles with all requests high, then released.
    v(1, 8'hFF, 8'h00, 0, 0, 0);
    v(1, 8'hFF, 8'h00, 0, 0, 0);
    v(0, 8'hFF, 8'h00, 0, 0, 0);
    v(0, 8'hFF, 8'h01, 0, 1, 1);
    v(0, 8'h00, 8'h01, 0, 1, 0);
    v(0, 8'h00, 8'h00, -1, 0, 0);

    // Single requester 3: burst limit re-grants with no gap.
    v(0, 8'h08, 8'h00, -1, 0, 0);
    for (int i = 0; i < 10; i++) v(0, 8'h08, 8'h08, 3, 1, 1);

    // Rotation between 7 and 0, four loads each.
    v(0, 8'h81, 8'h08, 3, 1, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) v(0, 8'h81, 8'h80, 7, 1, 1);
      for (int i = 0; i < 4; i++) v(0, 8'h81, 8'h01, 0, 1, 1);
    end

    // Early drop: owner 2 drops after two loads, 5 takes over next cycle.
    v(0, 8'h24, 8'h80, 7, 1, 0);
    v(0, 8'h24, 8'h04, 2, 1, 1);
    v(0, 8'h24, 8'h04, 2, 1, 1);
    v(0, 8'h20, 8'h04, 2, 1, 0);
    v(0, 8'h20, 8'h20, 5, 1, 1);

    // Wrap: grant to 6 leaves ptr=7, so 0 wins over a still-requesting 6.
    v(0, 8'h40, 8'h20, 5, 1, 0);
    v(0, 8'h40, 8'h40, 6, 1, 1);
    for (int i = 0; i < 3; i++) v(0, 8'h41, 8'h40, 6, 1, 1);
    v(0, 8'h41, 8'h01, 0, 1, 1);

    // Reset during the second load of owner 4, then fresh re-grant.
    v(0, 8'h10, 8'h01, 0, 1, 0);
    v(0, 8'h10, 8'h10, 4, 1, 1);
    v(1, 8'h10, 8'h10, 4, 1, 1);
    v(0, 8'h10, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) v(0, 8'h10, 8'h10, 4, 1, 1);
    v(0, 8'h00, 8'h10, 4, 1, 0);
    v(0, 8'h00, 8'h00, -1, 0, 0);

    repeat (3) @(posedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
